// File: rtl/fadd_share_sched.sv
// fadd_share_sched -- round-robin scheduler sharing one fixed-latency FP adder
// pipeline among NUM_REQ requesters.
//
// One operand pair is issued per cycle to the first eligible requester at or
// after rr_ptr. Eligible means it is requesting and still has a credit. Each
// issue is tagged with its requester ID in a shadow pipeline that advances with
// the adder. The tag leaving the pipeline steers the adder result into that
// requester's response FIFO.
//
// A requester's credits cover its in-flight results plus its buffered results,
// so a full FIFO is never written.
//
// Optional feature: define FADD_SHARE_CLKGATE_EN to gate ip_aclken when the
// block is idle. When it is not defined, ip_aclken is tied to 1.
//
// Ports:
//   aclk, areset            clock, asynchronous active-high reset
//   req_valid/req_ready     per-requester issue handshake (ready is the grant)
//   req_a, req_b            packed operands, requester i at [32i+31:32i]
//   rsp_valid/rsp_ready     per-requester response FIFO handshake
//   rsp_data                packed FIFO heads
//   ip_aclken               adder clock enable
//   ip_a_*, ip_b_*          adder operand channels (no backpressure)
//   ip_result_*             adder result channel
//   err_tag                 sticky: adder result strobe disagreed with tag tail

// Per-requester response FIFO plus issue credit counter.
module fadd_share_lane #(
    parameter int RSP_DEPTH = 4
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        issue,
    input  logic        push,
    input  logic [31:0] push_data,
    input  logic        pop_rdy,
    output logic        has_credit,
    output logic        rsp_valid,
    output logic [31:0] rsp_data
);
    localparam int AW = $clog2(RSP_DEPTH);
    localparam int CW = $clog2(RSP_DEPTH + 1);

    logic [CW-1:0] credit;
    logic [AW:0]   wr_ptr, rd_ptr;
    logic [31:0]   mem [RSP_DEPTH];
    logic          pop, full;

    assign rsp_valid  = (wr_ptr != rd_ptr);
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop        = rsp_valid && pop_rdy;
    assign has_credit = (credit != '0);
    // An empty FIFO presents zero rather than a stale entry.
    assign rsp_data   = rsp_valid ? mem[rd_ptr[AW-1:0]] : '0;

    always_ff @(posedge aclk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            credit <= CW'(RSP_DEPTH);
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (issue && !pop)      credit <= credit - CW'(1);
            else if (pop && !issue) credit <= credit + CW'(1);
        end
    end

    a_no_overflow: assert property (@(posedge aclk) disable iff (areset) !(push && full));
    a_credit_lo:   assert property (@(posedge aclk) disable iff (areset) !(issue && credit == '0));
endmodule

module fadd_share_sched #(
    parameter int NUM_REQ   = 4,
    parameter int LATENCY   = 7,
    parameter int RSP_DEPTH = 4
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*32-1:0] req_a,
    input  logic [NUM_REQ*32-1:0] req_b,
    output logic [NUM_REQ-1:0]    rsp_valid,
    input  logic [NUM_REQ-1:0]    rsp_ready,
    output logic [NUM_REQ*32-1:0] rsp_data,
    output logic                  ip_aclken,
    output logic                  ip_a_tvalid,
    output logic                  ip_b_tvalid,
    output logic [31:0]           ip_a_tdata,
    output logic [31:0]           ip_b_tdata,
    input  logic                  ip_result_tvalid,
    input  logic [31:0]           ip_result_tdata,
    output logic                  err_tag
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int SW = $clog2(LATENCY + 1);

    logic [NUM_REQ-1:0][31:0] a_arr, b_arr, rsp_arr;
    logic [NUM_REQ-1:0]       has_credit, eligible, grant, push;
    logic [IW-1:0]            rr_ptr, grant_id;
    logic                     issue;
    logic [LATENCY-1:0]       vld_pipe;
    logic [LATENCY-1:0][IW-1:0] id_pipe;
    logic                     tail_vld;
    logic [IW-1:0]            tail_id;
    logic [SW-1:0]            settle;

    assign a_arr    = req_a;
    assign b_arr    = req_b;
    assign rsp_data = rsp_arr;
    assign eligible = req_valid & has_credit;

`ifdef FADD_SHARE_CLKGATE_EN
    // Freeze the adder and the tag pipeline when nothing is in flight and
    // nobody can issue. Latency counts enabled cycles, so the result timing
    // relative to the tag pipeline is unaffected.
    assign ip_aclken = areset || (|vld_pipe) || (|eligible);
`else
    assign ip_aclken = 1'b1;
`endif

    // Cyclic priority search starting at rr_ptr. The search walks from the
    // farthest offset to the nearest, so the nearest eligible requester is
    // the last one written and wins.
    always_comb begin
        int idx;
        grant    = '0;
        grant_id = '0;
        idx      = 0;
        if (!areset && ip_aclken) begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                idx = int'(rr_ptr) + k;
                if (idx >= NUM_REQ) idx = idx - NUM_REQ;
                if (eligible[idx]) begin
                    grant      = '0;
                    grant[idx] = 1'b1;
                    grant_id   = IW'(idx);
                end
            end
        end
    end

    assign issue       = |grant;
    assign req_ready   = grant;
    assign ip_a_tvalid = issue;
    assign ip_b_tvalid = issue;
    assign ip_a_tdata  = issue ? a_arr[grant_id] : '0;
    assign ip_b_tdata  = issue ? b_arr[grant_id] : '0;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset)     rr_ptr <= '0;
        else if (issue) rr_ptr <= (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;
    end

    // The tag shadow pipeline tracks the adder stage by stage.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            vld_pipe <= '0;
            id_pipe  <= '0;
        end else if (ip_aclken) begin
            vld_pipe[0] <= issue;
            id_pipe[0]  <= grant_id;
            for (int s = 1; s < LATENCY; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
                id_pipe[s]  <= id_pipe[s-1];
            end
        end
    end

    assign tail_vld = vld_pipe[LATENCY-1];
    assign tail_id  = id_pipe[LATENCY-1];

    // Results from issues made before a reset can still drain out of the adder
    // during the first LATENCY enabled cycles after reset. Tag mismatches in
    // that window are ignored.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            settle  <= SW'(LATENCY);
            err_tag <= 1'b0;
        end else if (ip_aclken) begin
            if (settle != '0)                       settle  <= settle - 1'b1;
            else if (tail_vld != ip_result_tvalid)  err_tag <= 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        assign push[i] = ip_aclken && tail_vld && ip_result_tvalid && (int'(tail_id) == i);

        fadd_share_lane #(.RSP_DEPTH(RSP_DEPTH)) u_lane (
            .aclk       (aclk),
            .areset     (areset),
            .issue      (grant[i]),
            .push       (push[i]),
            .push_data  (ip_result_tdata),
            .pop_rdy    (rsp_ready[i]),
            .has_credit (has_credit[i]),
            .rsp_valid  (rsp_valid[i]),
            .rsp_data   (rsp_arr[i])
        );
    end
endmodule

// File: tb/tb_fadd_share_sched.sv
// Bench for fadd_share_sched. A behavioural adder (real arithmetic, LATENCY
// cycles deep) sits on the ip_* port. The reference model tracks the
// following:
//   - per-requester queues of expected results, each with its arrival cycle;
//   - outstanding counts that stand in for credits;
//   - a round-robin pointer;
//   - a cycle history of issues, used to predict tag-tail validity.
module tb_fadd_share_sched;
    localparam int NR = 4, L = 7, D = 4;

    logic              aclk = 1'b0, areset = 1'b1;
    logic [NR-1:0]     req_valid = '0, req_ready, rsp_valid, rsp_ready = '0;
    logic [NR*32-1:0]  req_a = '0, req_b = '0, rsp_data;
    logic              ip_aclken, ip_a_tvalid, ip_b_tvalid, err_tag;
    logic              ip_result_tvalid = 1'b0;
    logic [31:0]       ip_a_tdata, ip_b_tdata, ip_result_tdata = '0;

    always #5 aclk = ~aclk;

    fadd_share_sched #(.NUM_REQ(NR), .LATENCY(L), .RSP_DEPTH(D)) dut (
        .aclk(aclk), .areset(areset),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .ip_aclken(ip_aclken), .ip_a_tvalid(ip_a_tvalid), .ip_b_tvalid(ip_b_tvalid),
        .ip_a_tdata(ip_a_tdata), .ip_b_tdata(ip_b_tdata),
        .ip_result_tvalid(ip_result_tvalid), .ip_result_tdata(ip_result_tdata),
        .err_tag(err_tag)
    );

    typedef struct { logic [31:0] d; int t; } ent_t;

    int          nvec = 0, nmis = 0, cyc = 0, c0 = 0, rr = 0;
    ent_t        q [NR][$];
    int          outst [NR];
    int          dut_gcnt [NR];
    bit          exp_err = 1'b0;
    bit          hist [0:16383];
    logic [L-1:0] apv = '0;
    logic [31:0] apd [L];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    // Single-precision add via double arithmetic, truncating the mantissa.
    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        real         rs;
        logic [63:0] d;
        rs = f2r(a) + f2r(b);
        if (rs == 0.0) return 32'd0;
        d = $realtobits(rs);
        return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
    endfunction

    function automatic logic [31:0] rnd_f();
        return {1'($urandom), 8'(100 + $urandom_range(0, 50)), 23'($urandom)};
    endfunction

    // Behavioural adder: advances on ip_aclken, ignores areset.
    task automatic adder_shift(input bit en, input bit v, input logic [31:0] d);
        if (en) begin
            for (int k = L - 1; k > 0; k--) begin
                apv[k] = apv[k-1];
                apd[k] = apd[k-1];
            end
            apv[0] = v;
            apd[0] = d;
        end
        ip_result_tvalid = apv[L-1];
        ip_result_tdata  = apv[L-1] ? apd[L-1] : 32'hDEAD_BEEF;
    endtask

    task automatic rand_ops();
        for (int i = 0; i < NR; i++) begin
            req_a[i*32 +: 32] = rnd_f();
            req_b[i*32 +: 32] = rnd_f();
        end
    endtask

    // One clock cycle: check against the model, update the model, then clock.
    task automatic step();
        int            g;
        bit            tv, en, nv;
        logic [31:0]   nd;
        logic [NR-1:0] expv;
        ent_t          e;
        #1;
        g = -1;
        for (int k = 0; k < NR; k++) begin
            int i;
            i = (rr + k) % NR;
            if (g < 0 && req_valid[i] && outst[i] < D) g = i;
        end
        chk("req_ready", req_ready, (g < 0) ? 128'd0 : (128'd1 << g));
        chk("ip_tvalid", {ip_a_tvalid, ip_b_tvalid}, (g < 0) ? 128'd0 : 128'd3);
        if (g >= 0) begin
            chk("ip_a_tdata", ip_a_tdata, req_a[g*32 +: 32]);
            chk("ip_b_tdata", ip_b_tdata, req_b[g*32 +: 32]);
        end
        for (int i = 0; i < NR; i++) begin
            expv[i] = (q[i].size() > 0) && (q[i][0].t <= cyc);
            if (req_ready[i]) dut_gcnt[i]++;
        end
        chk("rsp_valid", rsp_valid, expv);
        for (int i = 0; i < NR; i++)
            if (expv[i]) chk("rsp_data", rsp_data[i*32 +: 32], q[i][0].d);
        chk("err_tag", err_tag, exp_err);
        chk("ip_aclken", ip_aclken, 1);

        tv = (cyc - L >= c0) && hist[cyc - L];
        if (cyc - c0 >= L && ip_result_tvalid != tv) exp_err = 1'b1;
        for (int i = 0; i < NR; i++)
            if (expv[i] && rsp_ready[i]) begin
                void'(q[i].pop_front());
                outst[i]--;
            end
        if (g >= 0) begin
            e.d = fadd(req_a[g*32 +: 32], req_b[g*32 +: 32]);
            e.t = cyc + L + 1;
            q[g].push_back(e);
            outst[g]++;
            rr = (g + 1) % NR;
            hist[cyc] = 1'b1;
        end
        en = ip_aclken;
        nv = ip_a_tvalid;
        nd = nv ? fadd(ip_a_tdata, ip_b_tdata) : 32'd0;
        @(posedge aclk);
        #1;
        cyc++;
        adder_shift(en, nv, nd);
    endtask

    task automatic do_reset(input int n);
        bit en, nv;
        areset = 1'b1;
        for (int k = 0; k < n; k++) begin
            #1;
            chk("rst_req_ready", req_ready, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_data", rsp_data, 0);
            chk("rst_ip_tvalid", {ip_a_tvalid, ip_b_tvalid}, 0);
            chk("rst_ip_tdata", {ip_a_tdata, ip_b_tdata}, 0);
            chk("rst_err_tag", err_tag, 0);
            chk("rst_ip_aclken", ip_aclken, 1);
            en = ip_aclken;
            nv = ip_a_tvalid;
            @(posedge aclk);
            #1;
            cyc++;
            adder_shift(en, nv, 32'd0);
        end
        areset = 1'b0;
        for (int i = 0; i < NR; i++) begin
            q[i].delete();
            outst[i] = 0;
        end
        rr      = 0;
        exp_err = 1'b0;
        c0      = cyc;
    endtask

    initial begin
        for (int i = 0; i < NR; i++) begin
            outst[i]    = 0;
            dut_gcnt[i] = 0;
        end
        for (int k = 0; k < L; k++) apd[k] = '0;
        req_valid = 4'b1111;               // reset must mask grants
        rand_ops();
        do_reset(3);
        req_valid = '0;

        // Single issue from requester 0 at cycle 10: 1.0 + 2.0.
        while (cyc < c0 + 10) step();
        req_valid = 4'b0001;
        req_a[31:0] = 32'h3F80_0000;
        req_b[31:0] = 32'h4000_0000;
        step();
        req_valid = '0;
        repeat (L) step();
        #1;
        chk("single_rsp", {rsp_valid, rsp_data[31:0]}, {4'b0001, 32'h4040_0000});
        rsp_ready = 4'b1111;
        step();

        // Every requester streams with responses drained: one grant per cycle, rotating.
        req_valid = 4'b1111;
        for (int i = 0; i < NR; i++) dut_gcnt[i] = 0;
        repeat (24) begin
            rand_ops();
            step();
        end
        for (int i = 0; i < NR; i++) chk("rr_share", dut_gcnt[i], 6);
        req_valid = '0;
        repeat (L + 3) step();

        // Requester 2 never pops, so its credits run out after RSP_DEPTH grants.
        req_valid = 4'b1111;
        rsp_ready = 4'b1011;
        for (int i = 0; i < NR; i++) dut_gcnt[i] = 0;
        repeat (30) begin
            rand_ops();
            step();
        end
        chk("r2_grants", dut_gcnt[2], D);
        #1;
        chk("r2_ready_low", req_ready[2], 0);
        chk("others_served", (dut_gcnt[0] > 5) && (dut_gcnt[1] > 5) && (dut_gcnt[3] > 5), 1);
        rsp_ready = 4'b1111;
        repeat (20) begin
            rand_ops();
            step();
        end
        req_valid = '0;
        repeat (L + D + 3) step();

        // Stray result strobe with an invalid tag tail sets err_tag, which then stays set.
        ip_result_tvalid = 1'b1;
        ip_result_tdata  = 32'h1234_5678;
        step();
        repeat (4) step();
        #1;
        chk("err_sticky", err_tag, 1);

        // Reset with 5 results in flight: they drain afterwards and are dropped silently.
        req_valid = 4'b1111;
        repeat (5) begin
            rand_ops();
            step();
        end
        req_valid = '0;
        do_reset(2);
        repeat (L + 4) step();
        #1;
        chk("post_rst_err", err_tag, 0);
        chk("post_rst_rsp", rsp_valid, 0);

        // Randomized traffic.
        repeat (600) begin
            req_valid = 4'($urandom);
            rsp_ready = 4'($urandom | $urandom);
            rand_ops();
            step();
        end
        req_valid = '0;
        rsp_ready = 4'b1111;
        repeat (L + D + 4) step();
        #1;
        chk("drained", rsp_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
